// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: the pipeline drives the decode/EX/cache status inputs
// through the master modport, and the controller drives the enables and forward selects.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 3,
    parameter int CNT_W     = 16
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);

    logic              icache_busy;
    logic              dcache_busy;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use1;
    logic              id_use2;
    logic [REG_AW-1:0] id_rd;
    logic              id_we;
    logic              id_is_load;
    logic              id_is_mc;
    logic              ex_taken;

    logic              pc_en;
    logic              if_id_en;
    logic              id_ex_en;
    logic              down_en;
    logic              flush_if_id;
    logic              bubble_id_ex;
    logic [SEL_W-1:0]  fwd_sel1;
    logic [SEL_W-1:0]  fwd_sel2;
    logic              mc_busy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output icache_busy, dcache_busy, id_valid, id_rs1, id_rs2, id_use1, id_use2,
               id_rd, id_we, id_is_load, id_is_mc, ex_taken,
        input  pc_en, if_id_en, id_ex_en, down_en, flush_if_id, bubble_id_ex,
               fwd_sel1, fwd_sel2, mc_busy, stall_cnt
    );

    modport slave (
        input  icache_busy, dcache_busy, id_valid, id_rs1, id_rs2, id_use1, id_use2,
               id_rd, id_we, id_is_load, id_is_mc, ex_taken,
        output pc_en, if_id_en, id_ex_en, down_en, flush_if_id, bubble_id_ex,
               fwd_sel1, fwd_sel2, mc_busy, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage hazard/stall controller: in-flight rd scoreboard, forward selects, load-use, MC hold.
// Enables/selects are combinational on registered state; cache busy freezes everything but the stall counter.
module pipeline_hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 3,
    parameter int MC_LAT    = 4,
    parameter int CNT_W     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);
    localparam int MCC_W = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;

    typedef enum logic {RUN, MC_WAIT} state_t;
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              ld;
    } sb_t;

    state_t            state_q, state_d;
    logic [MCC_W-1:0]  cnt_q, cnt_d;
    sb_t               sb_q [0:FWD_DEPTH];
    logic [REG_AW-1:0] ex_rs1_q, ex_rs2_q;
    logic              ex_use1_q, ex_use2_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic             busy, lu_hit, id_live;
    logic             pc_en, if_id_en, id_ex_en, down_en, flush, bubble;
    logic [SEL_W-1:0] fwd1, fwd2;

    assign busy   = hz.icache_busy | hz.dcache_busy;
    assign lu_hit = sb_q[0].ld & sb_q[0].we & (sb_q[0].rd != '0) & hz.id_valid &
                    ((hz.id_use1 & (hz.id_rs1 == sb_q[0].rd)) |
                     (hz.id_use2 & (hz.id_rs2 == sb_q[0].rd)));
    assign id_live = hz.id_valid & ~bubble;

    // Outputs are forced low while reset is asserted, independent of the clock.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        id_ex_en = 1'b0;
        down_en  = 1'b0;
        flush    = 1'b0;
        bubble   = 1'b0;
        if (!rst_ni || busy) begin
            state_d = state_q;
        end else if (state_q == RUN && hz.ex_taken) begin
            {pc_en, if_id_en, id_ex_en, down_en} = 4'b1111;
            flush  = 1'b1;
            bubble = 1'b1;
        end else if (state_q == MC_WAIT) begin
            down_en = 1'b1;
            if (cnt_q == '0) state_d = RUN;
            else             cnt_d   = cnt_q - 1'b1;
        end else if (lu_hit) begin
            id_ex_en = 1'b1;
            down_en  = 1'b1;
            bubble   = 1'b1;
        end else begin
            {pc_en, if_id_en, id_ex_en, down_en} = 4'b1111;
            if (MC_LAT > 1 && hz.id_valid && hz.id_is_mc) begin
                state_d = MC_WAIT;
                cnt_d   = MCC_W'(MC_LAT - 2);
            end
        end
    end

    // Descending scan so the youngest matching stage wins.
    always_comb begin
        fwd1 = '0;
        fwd2 = '0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (sb_q[k].we && sb_q[k].rd != '0 && ex_use1_q && sb_q[k].rd == ex_rs1_q)
                fwd1 = SEL_W'(k);
            if (sb_q[k].we && sb_q[k].rd != '0 && ex_use2_q && sb_q[k].rd == ex_rs2_q)
                fwd2 = SEL_W'(k);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_use1_q   <= 1'b0;
            ex_use2_q   <= 1'b0;
            stall_cnt_q <= '0;
            for (int k = 0; k <= FWD_DEPTH; k++) sb_q[k] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (id_ex_en) begin
                sb_q[0]   <= '{rd: hz.id_rd, we: hz.id_we & id_live, ld: hz.id_is_load & id_live};
                ex_rs1_q  <= hz.id_rs1;
                ex_rs2_q  <= hz.id_rs2;
                ex_use1_q <= hz.id_use1;
                ex_use2_q <= hz.id_use2;
            end
            if (down_en) begin
                // While EX is held by a multi-cycle op, a NOP drains into stage 1.
                sb_q[1] <= (state_q == MC_WAIT) ? '0 : sb_q[0];
                for (int k = 2; k <= FWD_DEPTH; k++) sb_q[k] <= sb_q[k-1];
            end
            if (!pc_en && stall_cnt_q != {CNT_W{1'b1}})
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.if_id_en     = if_id_en;
    assign hz.id_ex_en     = id_ex_en;
    assign hz.down_en      = down_en;
    assign hz.flush_if_id  = flush;
    assign hz.bubble_id_ex = bubble;
    assign hz.fwd_sel1     = fwd1;
    assign hz.fwd_sel2     = fwd2;
    assign hz.mc_busy      = (state_q == MC_WAIT);
    assign hz.stall_cnt    = stall_cnt_q;
endmodule
